// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with load, wrap pulse and a multiplexed 7-segment scan driver.
// Optional leading-zero blanking is compiled in with `define BCD_SCAN_LZB_EN.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;

  logic                  tick;
  logic                  carry;
  logic [3:0]            nib;
  logic [4*DIGITS-1:0]   stepped;
  logic [4*DIGITS-1:0]   clamped;
  logic [3:0]            scan_nib;
  logic                  blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    stepped = count_q;
    carry   = 1'b1;
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (nib == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  assign tick = en && (tick_cnt_q == TICK_LAST);

  // Load wins over a coincident tick and also restarts the prescaler.
  always_comb begin
    count_d    = count_q;
    tick_cnt_d = tick_cnt_q;
    wrap_d     = 1'b0;
    if (load) begin
      count_d    = clamped;
      tick_cnt_d = '0;
    end else if (en) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        count_d = stepped;
        wrap_d  = carry;
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  always_comb begin
    scan_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) scan_nib = count_q[4*i +: 4];
    end
    blank = 1'b0;
`ifdef BCD_SCAN_LZB_EN
    blank = (scan_idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= scan_idx_q) && (count_q[4*i +: 4] != 4'd0)) blank = 1'b0;
    end
`endif
    seg_d     = blank ? 7'h00 : decode(scan_nib);
    dig_sel_d = DIGITS'(1) << scan_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= 7'h00;
      dig_sel_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: a decimal-integer reference model predicts each cycle.
// A second instance with a slower prescaler exercises enable freezing.
module tb_bcd_scan_counter;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int FAST_TICK = 1;
  localparam int SLOW_TICK = 8;
  localparam int MOD       = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, up, load;
  logic [15:0] loadVal;
  logic [15:0] count;
  logic [6:0]  seg;
  logic [3:0]  digSel;
  logic        wrap;

  logic        slowEn, slowUp, slowLoad;
  logic [15:0] slowLoadVal;
  logic [15:0] slowCount;
  logic [6:0]  slowSeg;
  logic [3:0]  slowDigSel;
  logic        slowWrap;

  always #5 clk = ~clk;

  bcd_scan_counter #(.DIGITS(DIGITS), .TICK_DIV(FAST_TICK), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(loadVal),
    .count(count), .seg(seg), .dig_sel(digSel), .wrap(wrap)
  );

  bcd_scan_counter #(.DIGITS(DIGITS), .TICK_DIV(SLOW_TICK), .SCAN_DIV(SCAN_DIV)) dutSlow (
    .clk(clk), .rst_n(rst_n), .en(slowEn), .up(slowUp), .load(slowLoad), .load_val(slowLoadVal),
    .count(slowCount), .seg(slowSeg), .dig_sel(slowDigSel), .wrap(slowWrap)
  );

  typedef struct {
    logic [15:0] count;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  dig;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;

  int mCount, mTick, mScanCnt, mScanIdx;
  logic [6:0] segTable [10];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int digitOf(input int v, input int i);
    return (v / (10 ** i)) % 10;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(digitOf(v, i));
    return r;
  endfunction

  function automatic int fromLoad(input logic [15:0] lv);
    int v = 0;
    for (int i = 0; i < DIGITS; i++) v += ((lv[4*i +: 4] > 4'd9) ? 9 : int'(lv[4*i +: 4])) * (10 ** i);
    return v;
  endfunction

  task automatic resetModel();
    mCount = 0; mTick = 0; mScanCnt = 0; mScanIdx = 0;
    expQ.delete();
  endtask

  // Drive inputs for the next edge and push what the design should show after it.
  task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [15:0] lv);
    exp_t x;
    en = e; up = u; load = l; loadVal = lv;
    x.seg = segTable[digitOf(mCount, mScanIdx)];
`ifdef BCD_SCAN_LZB_EN
    if (mScanIdx > 0 && mCount < 10 ** mScanIdx) x.seg = 7'h00;
`endif
    x.dig = 4'(1 << mScanIdx);
    if (mScanCnt == SCAN_DIV - 1) begin
      mScanCnt = 0;
      mScanIdx = (mScanIdx + 1) % DIGITS;
    end else begin
      mScanCnt++;
    end
    x.wrap = 1'b0;
    if (l) begin
      mCount = fromLoad(lv);
      mTick = 0;
    end else if (e) begin
      if (mTick == FAST_TICK - 1) begin
        mTick = 0;
        if (u) begin
          if (mCount == MOD - 1) begin mCount = 0; x.wrap = 1'b1; end
          else mCount++;
        end else begin
          if (mCount == 0) begin mCount = MOD - 1; x.wrap = 1'b1; end
          else mCount--;
        end
      end else begin
        mTick++;
      end
    end
    x.count = toBcd(mCount);
    expQ.push_back(x);
  endtask

  task automatic cycle(input logic e, input logic u, input logic l, input logic [15:0] lv);
    exp_t x;
    applyStimulus(e, u, l, lv);
    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      x = expQ.pop_front();
      checkOutput("sb_count", 32'(count), 32'(x.count));
      checkOutput("sb_wrap", 32'(wrap), 32'(x.wrap));
      checkOutput("sb_seg", 32'(seg), 32'(x.seg));
      checkOutput("sb_dig_sel", 32'(digSel), 32'(x.dig));
    end
  endtask

  initial begin
    segTable = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    en = 0; up = 1; load = 0; loadVal = '0;
    slowEn = 0; slowUp = 1; slowLoad = 0; slowLoadVal = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_seg", 32'(seg), 32'd0);
    checkOutput("rst_dig_sel", 32'(digSel), 32'd0);
    checkOutput("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();

    repeat (10) cycle(1, 1, 0, 16'h0);
    checkOutput("t1_count", 32'(count), 32'h0010);

    cycle(1, 1, 1, 16'h9999);
    checkOutput("t2_load", 32'(count), 32'h9999);
    cycle(1, 1, 0, 16'h0);
    checkOutput("t2_rollover", 32'(count), 32'h0000);
    checkOutput("t2_wrap", 32'(wrap), 32'd1);
    cycle(0, 1, 0, 16'h0);
    checkOutput("t2_wrap_clear", 32'(wrap), 32'd0);

    cycle(1, 0, 0, 16'h0);
    checkOutput("t3_rollunder", 32'(count), 32'h9999);
    checkOutput("t3_wrap", 32'(wrap), 32'd1);
    cycle(0, 0, 0, 16'h0);
    checkOutput("t3_wrap_clear", 32'(wrap), 32'd0);

    cycle(1, 1, 1, 16'h0A3F);
    checkOutput("t4_clamp", 32'(count), 32'h0939);
    cycle(1, 1, 1, 16'h0A3F);
    checkOutput("t4_load_over_tick", 32'(count), 32'h0939);
    cycle(1, 1, 0, 16'h0);
    checkOutput("t4_carry", 32'(count), 32'h0940);

    cycle(0, 1, 1, 16'h0042);
    repeat (24) begin
      cycle(0, 1, 0, 16'h0);
      case (digSel)
        4'b0001: checkOutput("t5_seg_d0", 32'(seg), 32'h5B);
        4'b0010: checkOutput("t5_seg_d1", 32'(seg), 32'h66);
`ifdef BCD_SCAN_LZB_EN
        4'b0100: checkOutput("t5_seg_d2", 32'(seg), 32'h00);
        4'b1000: checkOutput("t5_seg_d3", 32'(seg), 32'h00);
`else
        4'b0100: checkOutput("t5_seg_d2", 32'(seg), 32'h3F);
        4'b1000: checkOutput("t5_seg_d3", 32'(seg), 32'h3F);
`endif
        default: checkOutput("t5_dig_onehot", 32'(digSel), 32'h1);
      endcase
    end

    repeat (300) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), 16'($urandom));
    end

    // Slow instance: advance the prescaler to 3, freeze it, then resume.
    slowEn = 1'b1;
    repeat (3) cycle(0, 1, 0, 16'h0);
    slowEn = 1'b0;
    repeat (50) cycle(0, 1, 0, 16'h0);
    checkOutput("t6_frozen_count", 32'(slowCount), 32'h0);
    slowEn = 1'b1;
    repeat (4) cycle(0, 1, 0, 16'h0);
    checkOutput("t6_before_tick", 32'(slowCount), 32'h0);
    cycle(0, 1, 0, 16'h0);
    checkOutput("t6_tick", 32'(slowCount), 32'h0001);
    checkOutput("t6_no_wrap", 32'(slowWrap), 32'd0);

    cycle(0, 1, 1, 16'h1234);
    checkOutput("t6_preload", 32'(count), 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_seg", 32'(seg), 32'd0);
    checkOutput("async_dig_sel", 32'(digSel), 32'd0);
    checkOutput("async_wrap", 32'(wrap), 32'd0);
    checkOutput("async_slow_count", 32'(slowCount), 32'd0);
    checkOutput("async_slow_seg", 32'(slowSeg), 32'd0);
    checkOutput("async_slow_dig_sel", 32'(slowDigSel), 32'd0);
    resetModel();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
